dinv_stim_checker: RTL

Digital stimulus-and-check stage that wraps the double-inverter analog macro. It drives a programmable square wave onto the pin feeding the inverter input, then samples the inverter output back through a synchronizer. It compares the returned signal against a delayed copy of the stimulus and counts rising edges and mismatching cycles. The project top instantiates it next to the analog macro and exposes its counters and status on the dedicated digital pins.

---
 rtl/dinv_pkg.sv | 14 +
 rtl/dinv_stim_checker_sync_ff.sv | 28 ++
 rtl/dinv_stim_checker.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dinv_pkg.sv
// Shared types and default sizing for the double-inverter stimulus/check stage.
package dinv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/dinv_stim_checker_sync_ff.sv
// Multi-stage bit synchronizer for an asynchronous input; all stages reset to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dinv_stim_checker.sv
// Drives a square-wave stimulus into the double-inverter macro and checks the
// synchronized response against a delayed copy, counting edges and mismatches.
module dinv_stim_checker
    import dinv_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       half_period,
    input  logic [7:0]       burst_len,
    output logic             stim_out,
    input  logic             resp_in,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DL = SYNC_STAGES + 1;
    localparam int unsigned DW = $clog2(DL);

    state_t           state_q, state_d;
    logic [7:0]       hp_q, hp_d;
    logic [7:0]       burst_q, burst_d;
    logic [7:0]       phase_q, phase_d;
    logic [7:0]       period_q, period_d;
    logic             stim_q, stim_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [DL-1:0]    dl_stim_q, dl_stim_d;
    logic [DL-1:0]    dl_vld_q, dl_vld_d;
    logic             resp_s_q, resp_s_d;
    logic [CNT_W-1:0] edge_q, edge_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic             resp_sync;
    logic             cmp_valid;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_resp_sync (
        .clk(clk),
        .rst(rst),
        .d  (resp_in),
        .q  (resp_sync)
    );

    always_comb begin
        state_d   = state_q;
        hp_d      = hp_q;
        burst_d   = burst_q;
        phase_d   = phase_q;
        period_d  = period_q;
        stim_d    = stim_q;
        drain_d   = drain_q;
        edge_d    = edge_q;
        mism_d    = mism_q;
        resp_s_d  = resp_sync;
        dl_stim_d = {dl_stim_q[DL-2:0], stim_q};
        dl_vld_d  = {dl_vld_q[DL-2:0], (state_q == S_RUN)};
        cmp_valid = dl_vld_q[DL-1];

        // Mismatch uses the sample register so exp and resp share SYNC_STAGES+1 latency.
        if (cmp_valid && (resp_s_q != dl_stim_q[DL-1]) && (mism_q != '1)) begin
            mism_d = mism_q + CNT_W'(1);
        end
        if (cmp_valid && resp_sync && !resp_s_q && (edge_q != '1)) begin
            edge_d = edge_q + CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !stop) begin
                    state_d  = S_RUN;
                    hp_d     = (half_period == 8'd0) ? 8'd1 : half_period;
                    burst_d  = burst_len;
                    phase_d  = '0;
                    period_d = '0;
                    stim_d   = 1'b0;
                    edge_d   = '0;
                    mism_d   = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_DRAIN;
                    stim_d  = 1'b0;
                    drain_d = '0;
                end else if (phase_q == hp_q - 8'd1) begin
                    phase_d = '0;
                    stim_d  = !stim_q;
                    if (stim_q) begin
                        period_d = period_q + 8'd1;
                        if ((burst_q != 8'd0) && (period_d == burst_q)) begin
                            state_d = S_DRAIN;
                            drain_d = '0;
                        end
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == DW'(DL - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hp_q      <= '0;
            burst_q   <= '0;
            phase_q   <= '0;
            period_q  <= '0;
            stim_q    <= 1'b0;
            drain_q   <= '0;
            dl_stim_q <= '0;
            dl_vld_q  <= '0;
            resp_s_q  <= 1'b0;
            edge_q    <= '0;
            mism_q    <= '0;
        end else begin
            state_q   <= state_d;
            hp_q      <= hp_d;
            burst_q   <= burst_d;
            phase_q   <= phase_d;
            period_q  <= period_d;
            stim_q    <= stim_d;
            drain_q   <= drain_d;
            dl_stim_q <= dl_stim_d;
            dl_vld_q  <= dl_vld_d;
            resp_s_q  <= resp_s_d;
            edge_q    <= edge_d;
            mism_q    <= mism_d;
        end
    end

    assign stim_out       = stim_q;
    assign edge_count     = edge_q;
    assign mismatch_count = mism_q;
    assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);

endmodule
